protection_checker: RTL and testbench

- Downstream consumer of the protection cell's RGZ output stream.
- RGZ fields: [7:6] phase counter, [5:3] sequence count, [2:0] data symbol.
- On each new symbol event, captures RGZ[2:0] and checks sequence continuity on RGZ[5:3].
- Assembles SYMS symbols into a word, compares it against CODE, and grants unlock or counts a failure; repeated failures latch a lockout.

---
 rtl/protection_checker.sv | 195 +++++++++++++++++++
 tb/tb_protection_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/protection_checker.sv
// protection_checker
// Consumes the protection cell's RGZ stream. Each rising edge of the phase
// field to 2'b11 is a symbol event. The block checks that sequence counts
// are continuous and assembles SYMS data symbols into a word. It then
// compares the word with CODE and either grants unlock or counts a failure.
// Reaching MAX_FAIL failures latches a lockout that only reset clears.
module protection_checker #(
    parameter int SYMS     = 4,  // symbols per word, must be >= 2
    parameter int SYM_W    = 3,  // symbol width, matches RGZ[2:0]
    parameter int MAX_FAIL = 3   // failed compares before lockout, 1..3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ENA,
    input  logic [1:0]              KEY,
    input  logic [7:0]              RGZ,
    input  logic [SYMS*SYM_W-1:0]   CODE,
    output logic [SYMS*SYM_W-1:0]   WORD,
    output logic                    WVLD,
    output logic                    UNLK,
    output logic                    SEQERR,
    output logic                    LOCKOUT,
    output logic [1:0]              FCNT
);

    localparam int WORD_W = SYMS * SYM_W;
    localparam int CNT_W  = $clog2(SYMS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       FAIL_LIM = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COLLECT    = 3'd1,
        COMPARE    = 3'd2,
        UNLOCKED   = 3'd3,
        LOCKED_OUT = 3'd4
    } state_t;

    // Registered state and its next-state values
    state_t              state_q,      state_d;
    logic [WORD_W-1:0]   word_q,       word_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [2:0]          last_seq_q,   last_seq_d;
    logic [1:0]          prev_phase_q, prev_phase_d;
    logic                wvld_q,       wvld_d;
    logic                seqerr_q,     seqerr_d;
    logic                unlk_q,       unlk_d;
    logic                lockout_q,    lockout_d;
    logic [1:0]          fcnt_q,       fcnt_d;

    // Helpers for the next-state logic
    logic                sym_evt;
    logic [2:0]          seq_expect;
    logic [SYM_W-1:0]    sym;
    logic [CNT_W-1:0]    cnt_acc;
    logic [1:0]          fcnt_inc;

    // KEY[1] is reserved; it is tied off here so that it is visibly consumed
    logic                unused_key1;
    assign unused_key1 = KEY[1];

    // A symbol event is the phase field entering 2'b11 from any other phase
    assign sym_evt    = (RGZ[7:6] == 2'b11) && (prev_phase_q != 2'b11);
    // Three-bit add, so a sequence count of 7 is followed by 0
    assign seq_expect = last_seq_q + 3'd1;
    assign sym        = RGZ[SYM_W-1:0];

    // State register and datapath; ENA low freezes everything, pulses included
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, whatever the statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            word_q       <= '0;
            cnt_q        <= '0;
            last_seq_q   <= '0;
            prev_phase_q <= 2'b00;
            wvld_q       <= 1'b0;
            seqerr_q     <= 1'b0;
            unlk_q       <= 1'b0;
            lockout_q    <= 1'b0;
            fcnt_q       <= '0;
        end else if (ENA) begin
            state_q      <= state_d;
            word_q       <= word_d;
            cnt_q        <= cnt_d;
            last_seq_q   <= last_seq_d;
            prev_phase_q <= prev_phase_d;
            wvld_q       <= wvld_d;
            seqerr_q     <= seqerr_d;
            unlk_q       <= unlk_d;
            lockout_q    <= lockout_d;
            fcnt_q       <= fcnt_d;
        end
    end

    // Next-state and next-output logic for the unlock sequence
    // NOTE: every variable gets a default before the case statement. A path
    // that leaves a variable unassigned would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        cnt_d        = cnt_q;
        last_seq_d   = last_seq_q;
        prev_phase_d = RGZ[7:6];
        wvld_d       = 1'b0;
        seqerr_d     = 1'b0;
        unlk_d       = unlk_q;
        lockout_d    = lockout_q;
        fcnt_d       = fcnt_q;
        cnt_acc      = cnt_q + CNT_ONE;
        fcnt_inc     = (fcnt_q == FAIL_LIM) ? fcnt_q : fcnt_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (KEY[0]) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end

            COLLECT: begin
                if (!KEY[0]) begin
                    // Abort takes priority over any symbol arriving now
                    state_d = IDLE;
                    cnt_d   = '0;
                    word_d  = '0;
                end else if (sym_evt) begin
                    last_seq_d = RGZ[5:3];
                    if ((cnt_q == '0) || (RGZ[5:3] == seq_expect)) begin
                        word_d  = {word_q[WORD_W-SYM_W-1:0], sym};
                        cnt_acc = cnt_q + CNT_ONE;
                    end else begin
                        // Break in the sequence: restart with this symbol first
                        seqerr_d = 1'b1;
                        word_d   = {{(WORD_W-SYM_W){1'b0}}, sym};
                        cnt_acc  = CNT_ONE;
                    end
                    cnt_d = cnt_acc;
                    if (cnt_acc == CNT_FULL) begin
                        state_d = COMPARE;
                        wvld_d  = 1'b1;
                    end
                end
            end

            COMPARE: begin
                if (!KEY[0]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    word_d  = '0;
                end else if (word_q == CODE) begin
                    unlk_d  = 1'b1;
                    state_d = UNLOCKED;
                end else begin
                    fcnt_d = fcnt_inc;
                    if (fcnt_inc == FAIL_LIM) begin
                        lockout_d = 1'b1;
                        state_d   = LOCKED_OUT;
                    end else begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                        word_d  = '0;
                    end
                end
            end

            UNLOCKED: begin
                if (!KEY[0]) begin
                    unlk_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            LOCKED_OUT: begin
                // Absorbing; only reset leaves this state
                unlk_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign WORD    = word_q;
    assign WVLD    = wvld_q;
    assign UNLK    = unlk_q;
    assign SEQERR  = seqerr_q;
    assign LOCKOUT = lockout_q;
    assign FCNT    = fcnt_q;

endmodule

// File: tb/tb_protection_checker.sv
// Testbench for protection_checker. The stimulus process queues the expected
// result of each completed word and each sequence break. The monitor process
// consumes those expectations whenever the DUT pulses WVLD or SEQERR.
module tb_protection_checker;

    logic        CLK;
    logic        RST;
    logic        ENA;
    logic [1:0]  KEY;
    logic [7:0]  RGZ;
    logic [11:0] CODE;
    logic [11:0] WORD;
    logic        WVLD;
    logic        UNLK;
    logic        SEQERR;
    logic        LOCKOUT;
    logic [1:0]  FCNT;

    typedef struct {
        logic [11:0] word;
        logic        unlk;
        logic [1:0]  fcnt;
        logic        lockout;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] seqerr_q[$];

    int n_checks = 0;
    int n_errors = 0;

    protection_checker #(.SYMS(4), .SYM_W(3), .MAX_FAIL(3)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ENA     (ENA),
        .KEY     (KEY),
        .RGZ     (RGZ),
        .CODE    (CODE),
        .WORD    (WORD),
        .WVLD    (WVLD),
        .UNLK    (UNLK),
        .SEQERR  (SEQERR),
        .LOCKOUT (LOCKOUT),
        .FCNT    (FCNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One symbol event followed by one idle-phase cycle
    task automatic send_sym(input logic [2:0] seq, input logic [2:0] d);
        RGZ = {2'b11, seq, d};
        tick();
        RGZ = {2'b00, seq, d};
        tick();
    endtask

    task automatic expect_word(input logic [11:0] w, input logic u, input logic [1:0] f, input logic l);
        exp_t e;
        e.word    = w;
        e.unlk    = u;
        e.fcnt    = f;
        e.lockout = l;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"},    32'(WORD),    32'h0);
        check({tag, "_wvld"},    32'(WVLD),    32'h0);
        check({tag, "_unlk"},    32'(UNLK),    32'h0);
        check({tag, "_seqerr"},  32'(SEQERR),  32'h0);
        check({tag, "_lockout"}, 32'(LOCKOUT), 32'h0);
        check({tag, "_fcnt"},    32'(FCNT),    32'h0);
    endtask

    // Monitor: compares pulses against queued expectations
    initial begin
        exp_t        e;
        logic [11:0] sw;
        forever begin
            @(negedge CLK);
            if (RST && SEQERR) begin
                check("seqerr_expected", 32'(seqerr_q.size() != 0), 32'h1);
                if (seqerr_q.size() != 0) begin
                    sw = seqerr_q.pop_front();
                    check("seqerr_word", 32'(WORD), 32'(sw));
                end
            end
            if (RST && WVLD) begin
                check("wvld_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wvld_word", 32'(WORD), 32'(e.word));
                    @(negedge CLK);
                    check("result_unlk",    32'(UNLK),    32'(e.unlk));
                    check("result_fcnt",    32'(FCNT),    32'(e.fcnt));
                    check("result_lockout", 32'(LOCKOUT), 32'(e.lockout));
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    // Stimulus
    initial begin
        RST  = 1'b0;
        ENA  = 1'b1;
        KEY  = 2'b00;
        RGZ  = 8'h00;
        CODE = 12'hA5C;
        tick();
        tick();
        check_all_zero("reset");
        RST = 1'b1;
        tick();

        // 1: basic unlock, data 5,1,3,4 with seq 2..5
        KEY = 2'b01;
        tick();
        expect_word(12'hA5C, 1'b1, 2'd0, 1'b0);
        send_sym(3'd2, 3'd5);
        send_sym(3'd3, 3'd1);
        send_sym(3'd4, 3'd3);
        send_sym(3'd5, 3'd4);
        KEY = 2'b00;
        tick();
        check("t1_unlk_cleared", 32'(UNLK), 32'h0);

        // 2: sequence wrap 6,7,0,1
        KEY = 2'b01;
        tick();
        expect_word(12'hA5C, 1'b1, 2'd0, 1'b0);
        send_sym(3'd6, 3'd5);
        send_sym(3'd7, 3'd1);
        send_sym(3'd0, 3'd3);
        send_sym(3'd1, 3'd4);
        KEY = 2'b00;
        tick();

        // 3: break at seq 5 restarts the word with symbol 3
        CODE = 12'h657;
        KEY  = 2'b01;
        tick();
        seqerr_q.push_back(12'h003);
        expect_word(12'h657, 1'b1, 2'd0, 1'b0);
        send_sym(3'd2, 3'd6);
        send_sym(3'd3, 3'd6);
        send_sym(3'd5, 3'd3);
        send_sym(3'd6, 3'd1);
        send_sym(3'd7, 3'd2);
        send_sym(3'd0, 3'd7);
        KEY = 2'b00;
        tick();

        // 4: three wrong words lock out
        CODE = 12'hA5C;
        KEY  = 2'b01;
        tick();
        expect_word(12'h000, 1'b0, 2'd1, 1'b0);
        expect_word(12'h000, 1'b0, 2'd2, 1'b0);
        expect_word(12'h000, 1'b0, 2'd3, 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int s = 0; s < 4; s++) send_sym(3'(s), 3'd0);
        end
        send_sym(3'd2, 3'd5);
        send_sym(3'd3, 3'd1);
        send_sym(3'd4, 3'd3);
        send_sym(3'd5, 3'd4);
        tick();
        check("t4_no_unlk",  32'(UNLK),    32'h0);
        check("t4_lockout",  32'(LOCKOUT), 32'h1);
        check("t4_fcnt_sat", 32'(FCNT),    32'h3);
        KEY = 2'b00;
        tick();
        KEY = 2'b01;
        tick();
        check("t4_lockout_key", 32'(LOCKOUT), 32'h1);
        check("t4_unlk_key",    32'(UNLK),    32'h0);
        RST = 1'b0;
        #1;
        check_all_zero("t4_rst");
        tick();
        RST = 1'b1;
        tick();

        // 5: held phase gives one symbol; ENA low freezes mid-word
        expect_word(12'hA5C, 1'b1, 2'd0, 1'b0);
        RGZ = {2'b11, 3'd2, 3'd5};
        repeat (4) tick();
        RGZ = 8'h00;
        tick();
        send_sym(3'd3, 3'd1);
        check("t5_partial_word", 32'(WORD), 32'h029);
        ENA = 1'b0;
        RGZ = {2'b11, 3'd7, 3'd7};
        tick();
        tick();
        RGZ = 8'h00;
        tick();
        check("t5_frozen_word", 32'(WORD), 32'h029);
        ENA = 1'b1;
        tick();
        send_sym(3'd4, 3'd3);
        send_sym(3'd5, 3'd4);

        // 6: asynchronous reset mid-word discards the partial word
        KEY = 2'b00;
        tick();
        KEY = 2'b01;
        tick();
        send_sym(3'd0, 3'd1);
        send_sym(3'd1, 3'd2);
        #3;
        RST = 1'b0;
        #1;
        check_all_zero("t6_async_rst");
        tick();
        RST = 1'b1;
        tick();
        expect_word(12'hA5C, 1'b1, 2'd0, 1'b0);
        send_sym(3'd3, 3'd5);
        send_sym(3'd4, 3'd1);
        send_sym(3'd5, 3'd3);
        send_sym(3'd6, 3'd4);

        // 6b: KEY[0]=0 wins over a simultaneous symbol event
        KEY = 2'b00;
        tick();
        KEY = 2'b01;
        tick();
        send_sym(3'd0, 3'd5);
        RGZ = {2'b11, 3'd1, 3'd1};
        KEY = 2'b00;
        tick();
        check("t6_key_word",   32'(WORD),   32'h0);
        check("t6_key_seqerr", 32'(SEQERR), 32'h0);
        check("t6_key_unlk",   32'(UNLK),   32'h0);
        RGZ = 8'h00;
        repeat (3) tick();

        check("pending_words",   32'(exp_q.size()),    32'h0);
        check("pending_seqerrs", 32'(seqerr_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
